// File: rtl/bram_arb_if.sv
// Multi-channel BRAM port arbiter: NUM_CH read requesters plus one write requester, one access in flight.
// Optional build macro BRAM_ARB_FIXED_PRIO_EN selects fixed-priority read arbitration instead of round-robin.
module bram_arb_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     nn_clk,
  input  logic                     nn_rst_n,
  input  logic [NUM_CH-1:0]        ch_start_read,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic [NUM_CH-1:0]        ch_complete,
  input  logic                     wr_start,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_complete,
  output logic                     busy,
  output logic                     clk_BRAM,
  output logic                     rst_BRAM,
  output logic                     en_BRAM,
  output logic [DATA_W/8-1:0]      we_BRAM,
  output logic [ADDR_W-1:0]        addr_BRAM,
  output logic [DATA_W-1:0]        dout_BRAM,
  input  logic [DATA_W-1:0]        din_BRAM
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD_WAIT = 2'd1, S_WR_DONE = 2'd2} state_t;

  state_t                          r_state, w_state_nxt;
  logic [2:0]                      r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0]               r_pend, w_pend_nxt, w_acc, w_clr;
  logic                            r_pend_wr, w_pend_wr_nxt, w_acc_wr;
  logic [NUM_CH-1:0][ADDR_W-1:0]   r_ch_addr, w_ch_addr_nxt, w_ch_addr_in;
  logic [ADDR_W-1:0]               r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0]               r_wr_data, w_wr_data_nxt;
  logic [PTR_W-1:0]                r_cur, w_cur_nxt, w_sel;
  logic                            r_en, w_en_nxt;
  logic [BE_W-1:0]                 r_we, w_we_nxt;
  logic [ADDR_W-1:0]               r_addr, w_addr_nxt;
  logic [DATA_W-1:0]               r_dout, w_dout_nxt;
  logic [NUM_CH-1:0][DATA_W-1:0]   r_rdata;
  logic [NUM_CH-1:0]               r_ch_cmp;
  logic                            r_wr_cmp, r_busy;
  logic                            w_rd_done, w_wr_done, w_arb;
`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]                r_ptr, w_ptr_nxt;
  int                              w_idx;
`endif

  assign w_ch_addr_in  = ch_addr;
  assign w_rd_done     = (r_state == S_RD_WAIT) && (r_cnt == 3'd0);
  assign w_wr_done     = (r_state == S_WR_DONE);
  assign w_clr         = w_rd_done ? (NUM_CH'(1) << r_cur) : '0;
  // A pulse is only accepted when its channel has nothing pending; the clear lands first.
  assign w_acc         = ch_start_read & ~r_pend;
  assign w_acc_wr      = wr_start & ~r_pend_wr;
  assign w_pend_nxt    = (r_pend & ~w_clr) | w_acc;
  assign w_pend_wr_nxt = (r_pend_wr & ~w_wr_done) | w_acc_wr;
  assign w_wr_addr_nxt = w_acc_wr ? wr_addr : r_wr_addr;
  assign w_wr_data_nxt = w_acc_wr ? wr_data : r_wr_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
    assign w_ch_addr_nxt[g] = w_acc[g] ? w_ch_addr_in[g] : r_ch_addr[g];
  end

  // Read channel selection over the post-edge pending set
  always_comb begin
    w_sel = '0;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_sel = w_pend_nxt[PTR_W'(i)] ? PTR_W'(i) : w_sel;
    end
`else
    w_idx = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = (int'(r_ptr) + k) % NUM_CH;
      w_sel = w_pend_nxt[PTR_W'(w_idx)] ? PTR_W'(w_idx) : w_sel;
    end
`endif
  end

  // Next state and next registered BRAM-side outputs; a grant decided here is driven the following cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_en_nxt    = 1'b0;
    w_we_nxt    = '0;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_arb       = 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    w_ptr_nxt   = r_ptr;
`endif
    case (r_state)
      S_IDLE:    w_arb = 1'b1;
      S_RD_WAIT: begin
        if (w_rd_done) begin
          w_state_nxt = S_IDLE;
          w_arb       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_WR_DONE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_arb && w_pend_wr_nxt) begin
      w_en_nxt    = 1'b1;
      w_we_nxt    = '1;
      w_addr_nxt  = w_wr_addr_nxt;
      w_dout_nxt  = w_wr_data_nxt;
      w_state_nxt = S_WR_DONE;
    end else if (w_arb && (|w_pend_nxt)) begin
      w_en_nxt    = 1'b1;
      w_addr_nxt  = w_ch_addr_nxt[w_sel];
      w_cur_nxt   = w_sel;
      w_cnt_nxt   = 3'(RD_LAT);
      w_state_nxt = S_RD_WAIT;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      w_ptr_nxt   = w_sel;
`endif
    end else begin
      w_en_nxt = 1'b0;
    end
  end

  // State, request bookkeeping and all registered outputs
  always_ff @(posedge nn_clk) begin
    if (!nn_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
      r_ch_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cur     <= '0;
      r_en      <= 1'b0;
      r_we      <= '0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rdata   <= '0;
      r_ch_cmp  <= '0;
      r_wr_cmp  <= 1'b0;
      r_busy    <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      r_ptr     <= PTR_W'(NUM_CH - 1);
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_wr <= w_pend_wr_nxt;
      r_ch_addr <= w_ch_addr_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_cur     <= w_cur_nxt;
      r_en      <= w_en_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_dout    <= w_dout_nxt;
      if (w_rd_done) begin
        r_rdata[r_cur] <= din_BRAM;
      end
      r_ch_cmp  <= w_clr;
      r_wr_cmp  <= w_wr_done;
      // The write-done cycle still counts as busy even though the pending flag is already gone.
      r_busy    <= (|w_pend_nxt) | w_pend_wr_nxt | (w_state_nxt != S_IDLE) | w_wr_done;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      r_ptr     <= w_ptr_nxt;
`endif
    end
  end

  assign ch_rdata    = r_rdata;
  assign ch_complete = r_ch_cmp;
  assign wr_complete = r_wr_cmp;
  assign busy        = r_busy;
  assign clk_BRAM    = nn_clk;
  assign rst_BRAM    = ~nn_rst_n;
  assign en_BRAM     = r_en;
  assign we_BRAM     = r_we;
  assign addr_BRAM   = r_addr;
  assign dout_BRAM   = r_dout;
endmodule

// File: tb/tb_bram_arb_if.sv
// Self-checking bench for bram_arb_if: directed scenarios plus a randomized read phase
// checked against a memory/pending-set reference model. Second instance uses RD_LAT=3.
module tb_bram_arb_if;
  logic        nn_clk = 1'b0;
  logic        nn_rst_n;
  logic [1:0]  ch_start_read;
  logic [63:0] ch_addr;
  logic [63:0] ch_rdata;
  logic [1:0]  ch_complete;
  logic        wr_start;
  logic [31:0] wr_addr, wr_data;
  logic        wr_complete, busy, clk_BRAM, rst_BRAM, en_BRAM;
  logic [3:0]  we_BRAM;
  logic [31:0] addr_BRAM, dout_BRAM, din_BRAM;

  logic [1:0]  s3_start;
  logic [63:0] s3_addr;
  logic [63:0] s3_rdata;
  logic [1:0]  s3_cmp;
  logic        s3_wr_start;
  logic [31:0] s3_wr_addr, s3_wr_data;
  logic        s3_wr_cmp, s3_busy, s3_clk, s3_rst, s3_en;
  logic [3:0]  s3_we;
  logic [31:0] s3_addr_b, s3_dout;
  logic [31:0] s3_pipe [0:2];
  logic [31:0] s3_din;

  int checks = 0;
  int errors = 0;
  logic [31:0]  seed;
  logic [31:0]  tb_mem [0:255];
  logic [255:0] tb_wv = '0;
  logic [31:0]  mdl_mem [0:255];

  always #5 nn_clk = ~nn_clk;

  bram_arb_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RD_LAT(1)) dut (
    .nn_clk(nn_clk), .nn_rst_n(nn_rst_n), .ch_start_read(ch_start_read), .ch_addr(ch_addr),
    .ch_rdata(ch_rdata), .ch_complete(ch_complete), .wr_start(wr_start), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_complete(wr_complete), .busy(busy), .clk_BRAM(clk_BRAM),
    .rst_BRAM(rst_BRAM), .en_BRAM(en_BRAM), .we_BRAM(we_BRAM), .addr_BRAM(addr_BRAM),
    .dout_BRAM(dout_BRAM), .din_BRAM(din_BRAM));

  bram_arb_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RD_LAT(3)) dut3 (
    .nn_clk(nn_clk), .nn_rst_n(nn_rst_n), .ch_start_read(s3_start), .ch_addr(s3_addr),
    .ch_rdata(s3_rdata), .ch_complete(s3_cmp), .wr_start(s3_wr_start), .wr_addr(s3_wr_addr),
    .wr_data(s3_wr_data), .wr_complete(s3_wr_cmp), .busy(s3_busy), .clk_BRAM(s3_clk),
    .rst_BRAM(s3_rst), .en_BRAM(s3_en), .we_BRAM(s3_we), .addr_BRAM(s3_addr_b),
    .dout_BRAM(s3_dout), .din_BRAM(s3_din));

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'hDEAD_BEEF;
    return (32'(idx) * 32'h9E37_79B9) ^ seed;
  endfunction

  // One-cycle-latency BRAM; data bus carries junk whenever no read was issued.
  always @(posedge nn_clk) begin
    if (en_BRAM && we_BRAM == 4'hF) begin
      tb_mem[addr_BRAM[9:2]] <= dout_BRAM;
      tb_wv[addr_BRAM[9:2]]  <= 1'b1;
    end
    if (en_BRAM && we_BRAM == 4'h0)
      din_BRAM <= tb_wv[addr_BRAM[9:2]] ? tb_mem[addr_BRAM[9:2]] : init_word(int'(addr_BRAM[9:2]));
    else
      din_BRAM <= $urandom;
  end

  // Three-cycle-latency BRAM for the second instance
  always @(posedge nn_clk) begin
    s3_pipe[0] <= (s3_en && s3_we == 4'h0) ? (s3_addr_b ^ 32'h5A5A_0000) : $urandom;
    s3_pipe[1] <= s3_pipe[0];
    s3_pipe[2] <= s3_pipe[1];
  end
  assign s3_din = s3_pipe[2];

  task automatic tick;
    @(negedge nn_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  pend_m;
  logic [31:0] exp_d [0:1];
  int          t_req [0:1];
  int          cyc [0:1];
  int          mptr, first, n0, c0;
  int          a;

  initial begin
    seed = $urandom;
    nn_rst_n = 1'b0;
    ch_start_read = '0; ch_addr = '0; wr_start = 1'b0; wr_addr = '0; wr_data = '0;
    s3_start = '0; s3_addr = '0; s3_wr_start = 1'b0; s3_wr_addr = '0; s3_wr_data = '0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
    mptr = 1;
    repeat (3) tick;

    // reset state
    chk("rst_en", 64'(en_BRAM), 64'(1'b0));
    chk("rst_we", 64'(we_BRAM), 64'(4'h0));
    chk("rst_addr", 64'(addr_BRAM), 64'(32'h0));
    chk("rst_dout", 64'(dout_BRAM), 64'(32'h0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_cmp", 64'({ch_complete, wr_complete}), 64'(3'b000));
    chk("rst_rdata", ch_rdata, 64'h0);
    chk("rst_bram_hi", 64'(rst_BRAM), 64'(1'b1));
    nn_rst_n = 1'b1;
    tick;
    chk("rst_bram_lo", 64'(rst_BRAM), 64'(1'b0));

    // single read on both latencies
    ch_start_read = 2'b01; ch_addr[31:0] = 32'h10;
    s3_start = 2'b01; s3_addr[31:0] = 32'h44;
    tick;
    ch_start_read = '0; s3_start = '0;
    chk("rd_en", 64'(en_BRAM), 64'(1'b1));
    chk("rd_we", 64'(we_BRAM), 64'(4'h0));
    chk("rd_addr", 64'(addr_BRAM), 64'(32'h10));
    chk("rd_busy", 64'(busy), 64'(1'b1));
    chk("l3_en", 64'(s3_en), 64'(1'b1));
    chk("l3_addr", 64'(s3_addr_b), 64'(32'h44));
    tick;
    chk("rd_en_off", 64'(en_BRAM), 64'(1'b0));
    chk("rd_cmp_early", 64'(ch_complete), 64'(2'b00));
    tick;
    chk("rd_cmp", 64'(ch_complete), 64'(2'b01));
    chk("rd_data", 64'(ch_rdata[31:0]), 64'(32'hDEAD_BEEF));
    chk("l3_cmp_early", 64'(s3_cmp), 64'(2'b00));
    tick;
    chk("rd_cmp_once", 64'(ch_complete), 64'(2'b00));
    chk("rd_busy_off", 64'(busy), 64'(1'b0));
    chk("l3_cmp_s4", 64'(s3_cmp), 64'(2'b00));
    tick;
    chk("l3_cmp", 64'(s3_cmp), 64'(2'b01));
    chk("l3_data", 64'(s3_rdata[31:0]), 64'(32'h44 ^ 32'h5A5A_0000));
    mptr = 0;

    // write then read back on channel 1
    wr_start = 1'b1; wr_addr = 32'h20; wr_data = 32'h1234_5678;
    tick;
    wr_start = 1'b0;
    mdl_mem[8] = 32'h1234_5678;
    chk("wr_en", 64'(en_BRAM), 64'(1'b1));
    chk("wr_we", 64'(we_BRAM), 64'(4'hF));
    chk("wr_addr", 64'(addr_BRAM), 64'(32'h20));
    chk("wr_dout", 64'(dout_BRAM), 64'(32'h1234_5678));
    tick;
    chk("wr_cmp", 64'(wr_complete), 64'(1'b1));
    chk("wr_busy", 64'(busy), 64'(1'b1));
    chk("wr_hold_addr", 64'(addr_BRAM), 64'(32'h20));
    tick;
    chk("wr_cmp_once", 64'(wr_complete), 64'(1'b0));
    chk("wr_busy_off", 64'(busy), 64'(1'b0));
    ch_start_read = 2'b10; ch_addr[63:32] = 32'h20;
    tick;
    ch_start_read = '0;
    tick; tick;
    chk("rb_cmp", 64'(ch_complete), 64'(2'b10));
    chk("rb_data", 64'(ch_rdata[63:32]), 64'(mdl_mem[8]));
    chk("rb_hold0", 64'(ch_rdata[31:0]), 64'(32'hDEAD_BEEF));
    mptr = 1;

    // simultaneous requests, twice: round-robin order and bounded completion
    for (int p = 0; p < 2; p++) begin
      ch_addr = {32'h20, 32'h10};
      ch_start_read = 2'b11;
      first = (mptr + 1) % 2;
      cyc[0] = -1; cyc[1] = -1;
      tick;
      ch_start_read = '0;
      for (int c = 1; c <= 8; c++) begin
        for (int k = 0; k < 2; k++) if (ch_complete[k]) cyc[k] = c;
        tick;
      end
      chk("rr_first", 64'(cyc[first]), 64'(3));
      chk("rr_second", 64'(cyc[1 - first]), 64'(5));
      mptr = 1 - first;
    end
    chk("rr_data0", 64'(ch_rdata[31:0]), 64'(mdl_mem[4]));
    chk("rr_data1", 64'(ch_rdata[63:32]), 64'(mdl_mem[8]));

    // write wins over a simultaneous read; a repeat pulse while pending is dropped
    wr_start = 1'b1; wr_addr = 32'h30; wr_data = 32'hCAFE_F00D;
    ch_start_read = 2'b01; ch_addr[31:0] = 32'h10;
    tick;
    wr_start = 1'b0;
    mdl_mem[12] = 32'hCAFE_F00D;
    chk("pri_we", 64'(we_BRAM), 64'(4'hF));
    chk("pri_addr", 64'(addr_BRAM), 64'(32'h30));
    ch_start_read = 2'b01; ch_addr[31:0] = 32'h20;
    tick;
    ch_start_read = '0;
    n0 = 0; c0 = -1;
    for (int c = 2; c <= 12; c++) begin
      if (ch_complete[0]) begin n0++; c0 = c; end
      tick;
    end
    chk("drop_count", 64'(n0), 64'(1));
    chk("drop_cycle", 64'(c0), 64'(5));
    chk("drop_data", 64'(ch_rdata[31:0]), 64'(mdl_mem[4]));
    mptr = 0;

    // reset while a read is outstanding
    ch_start_read = 2'b10; ch_addr[63:32] = 32'h30;
    tick;
    ch_start_read = '0;
    chk("mid_en", 64'(en_BRAM), 64'(1'b1));
    nn_rst_n = 1'b0;
    tick;
    chk("mid_busy", 64'(busy), 64'(1'b0));
    chk("mid_rdata", ch_rdata, 64'h0);
    chk("mid_cmp", 64'(ch_complete), 64'(2'b00));
    chk("mid_rst_bram", 64'(rst_BRAM), 64'(1'b1));
    chk("mid_en_off", 64'(en_BRAM), 64'(1'b0));
    tick;
    nn_rst_n = 1'b1;
    n0 = 0;
    for (int c = 0; c < 4; c++) begin
      if (ch_complete != 2'b00) n0++;
      tick;
    end
    chk("mid_no_cmp", 64'(n0), 64'(0));
    mptr = 1;
    ch_start_read = 2'b01; ch_addr[31:0] = 32'h30;
    tick;
    ch_start_read = '0;
    tick; tick;
    chk("post_cmp", 64'(ch_complete), 64'(2'b01));
    chk("post_data", 64'(ch_rdata[31:0]), 64'(mdl_mem[12]));
    chk("post_rdata1", 64'(ch_rdata[63:32]), 64'(32'h0));
    tick;

    // randomized reads against the pending-set / memory model
    pend_m = '0;
    for (int c = 0; c < 420; c++) begin
      ch_start_read = '0;
      for (int k = 0; k < 2; k++) begin
        if (ch_complete[k]) begin
          chk("rnd_expected", 64'(pend_m[k]), 64'(1'b1));
          chk("rnd_data", 64'(ch_rdata[k*32 +: 32]), 64'(exp_d[k]));
          chk("rnd_latency", 64'((c - t_req[k]) <= 5), 64'(1'b1));
          pend_m[k] = 1'b0;
        end
      end
      chk("rnd_busy", 64'(busy), 64'(|pend_m));
      if (c < 400) begin
        for (int k = 0; k < 2; k++) begin
          if ($urandom_range(0, 2) == 0) begin
            a = int'($urandom_range(0, 15));
            ch_start_read[k] = 1'b1;
            ch_addr[k*32 +: 32] = 32'(a) << 2;
            if (!pend_m[k]) begin
              pend_m[k] = 1'b1;
              exp_d[k]  = mdl_mem[a];
              t_req[k]  = c;
            end
          end
        end
      end
      tick;
    end
    chk("rnd_drained", 64'(pend_m), 64'(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_arb_if.md
Name: bram_arb_if

Overview:
- Parametrised successor to the single-requester BRAM interface.
- Arbitrates NUM_CH independent read requesters (NN layer engines, AXI read path) plus one write requester onto a single BRAM port.
- Configurable data width, address width and BRAM read latency.
- Sits between NN_top instances / AXI slave logic and the BRAM macro; one access in flight at a time.

Parameters:
- NUM_CH, 2, number of read requester channels (1..8).
- DATA_W, 32, BRAM data width in bits (multiple of 8).
- ADDR_W, 32, BRAM address width (byte address, passed through unmodified).
- RD_LAT, 1, BRAM read latency in cycles from en_BRAM to valid din_BRAM (1..4).

Ports:
- nn_clk  in  1  single clock; also drives clk_BRAM.
- nn_rst_n  in  1  synchronous, active-low reset.
- ch_start_read  in  NUM_CH  per-channel one-cycle read request pulse.
- ch_addr  in  NUM_CH*ADDR_W  per-channel read address; channel i at [i*ADDR_W +: ADDR_W], sampled with the pulse.
- ch_rdata  out  NUM_CH*DATA_W  per-channel read data, held until that channel's next completion.
- ch_complete  out  NUM_CH  per-channel one-cycle completion pulse.
- wr_start  in  1  write request pulse.
- wr_addr  in  ADDR_W  write address, sampled with the pulse.
- wr_data  in  DATA_W  write data, sampled with the pulse.
- wr_complete  out  1  one-cycle write completion pulse.
- busy  out  1  high when any request is pending or in flight.
- clk_BRAM  out  1  equals nn_clk.
- rst_BRAM  out  1  equals ~nn_rst_n.
- en_BRAM  out  1  BRAM enable.
- we_BRAM  out  DATA_W/8  byte write enables.
- addr_BRAM  out  ADDR_W  BRAM address.
- dout_BRAM  out  DATA_W  write data to BRAM.
- din_BRAM  in  DATA_W  read data from BRAM.

Behaviour:
- Reset (nn_rst_n low at an edge): all outputs 0 except clk_BRAM and rst_BRAM (rst_BRAM=1 while in reset).
  - Pending flags and latched addresses/data cleared; RR pointer set to NUM_CH-1; FSM to IDLE.
  - Reset mid-access aborts it: no complete pulse, ch_rdata cleared.
- Request capture:
  - A pulse on ch_start_read[i] at edge S sets pend[i] and latches ch_addr[i].
  - A pulse while pend[i] is already set is ignored (dropped, no queueing). wr_start behaves the same against pend_wr.
- FSM states:
  - IDLE: when any request is pending, grant it. pend_wr has priority over reads.
    - Read grant: the first pend[j] scanning j = ptr+1 .. ptr+NUM_CH mod NUM_CH.
    - Read grant drives en_BRAM=1, we_BRAM=0, addr_BRAM=latched addr for exactly one cycle; ptr<=j; go to RD_WAIT with cnt=RD_LAT.
    - Write grant drives en_BRAM=1, we_BRAM=all ones, addr_BRAM, dout_BRAM for one cycle; go to WR_DONE.
  - RD_WAIT: cnt decrements each cycle.
    - At the edge where cnt reaches 0: ch_rdata[j] <= din_BRAM, clear pend[j], pulse ch_complete[j] for the next cycle, go to IDLE.
  - WR_DONE: clear pend_wr, pulse wr_complete for one cycle, go to IDLE.
- Latency:
  - Uncontended read: start pulse at cycle S, en_BRAM in S+1, ch_complete in S+RD_LAT+2 (RD_LAT=1 -> S+3).
  - Uncontended write: en_BRAM in S+1, wr_complete in S+2.
- Throughput:
  - Back-to-back grants allowed. The IDLE cycle that pulses complete may also issue the next grant.
- Outputs when not granting:
  - en_BRAM=0 and we_BRAM=0.
  - addr_BRAM and dout_BRAM hold their last value.
- busy = |pend | pend_wr | (state != IDLE).
- A new pulse on a channel in the same cycle its ch_complete is high is accepted (pend cleared at the earlier edge).

Optional Feature:
- BRAM_ARB_FIXED_PRIO_EN.
  - Defined: read arbitration is fixed priority, lowest channel index wins; RR pointer removed.
  - Undefined (default): round-robin as above.
- Write priority over reads is unchanged in both builds.

Test Plan:
- Single read: NUM_CH=2, RD_LAT=1, BRAM preloaded addr 0x10=0xDEADBEEF; pulse ch 0 with addr 0x10 at S.
  - Expect en_BRAM=1 at S+1, ch_complete[0] at S+3, ch_rdata[0]=0xDEADBEEF.
- Write then readback: wr 0x20 <- 0x12345678.
  - Expect we_BRAM=4'hF at S+1 and wr_complete at S+2.
  - Then a ch 1 read of 0x20 returns 0x12345678.
- Round-robin: ch 0 and ch 1 pulse in the same cycle, twice in succession.
  - First pair: order ch 0 then ch 1 (ptr reset = 1).
  - Second pair: order ch 0 then ch 1 again (ptr=1 after the first pair).
  - No starvation; both complete within 2*(RD_LAT+1)+1 cycles.
- Write priority and drop: wr and ch 0 pulse together; ch 0 pulses again while pending.
  - Expect write granted first.
  - Exactly one ch_complete[0].
- Latency sweep: RD_LAT=3 build, single read.
  - Expect ch_complete at S+5 and data captured from din_BRAM 3 cycles after en_BRAM.
- Reset mid-read: assert nn_rst_n=0 during RD_WAIT.
  - Expect no ch_complete, busy=0, ch_rdata=0, rst_BRAM=1 during reset.
  - A fresh read after release completes normally.
